// File: rtl/mips_pkg.sv
// Shared opcode, jump-code and FSM definitions for the ID/redirect stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [1:0] JMP_SEQ = 2'b00;
    localparam logic [1:0] JMP_ABS = 2'b01;
    localparam logic [1:0] JMP_REG = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10
    } id_state_e;

    // Branch displacement in bytes: sign-extended word offset times four.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational load-use and branch-operand hazard detection for the ID stage.
module id_hazard_unit
    import mips_pkg::*;
(
    input  logic       id_valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       idex_mem_read,
    input  logic       idex_reg_write,
    input  logic [4:0] idex_dst,
    output logic       stall
);

    logic is_branch;
    logic is_jr;
    logic reads_rt;
    logic rs_match;
    logic rt_match;
    logic load_use;
    logic branch_hazard;

    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_jr     = (opcode == OP_RTYPE) && (funct == FUNCT_JR);
    assign reads_rt  = (opcode == OP_RTYPE) || is_branch;

    // $0 is hard-wired, so a write to it never feeds a dependent reader.
    assign rs_match = (idex_dst != 5'd0) && (idex_dst == rs);
    assign rt_match = (idex_dst != 5'd0) && (idex_dst == rt);

    assign load_use      = idex_mem_read && (rs_match || (rt_match && reads_rt));
    // Branch operands are compared in ID with no forwarding path, so any
    // in-flight producer of a source must retire first.
    assign branch_hazard = idex_reg_write &&
                           ((is_branch && (rs_match || rt_match)) || (is_jr && rs_match));

    assign stall = id_valid && (load_use || branch_hazard);

endmodule

// File: rtl/id_redirect_stage.sv
// IF/ID register, decode and next-PC redirect controls with hazard stalling.
// Define BRANCH_DELAY_SLOT_EN to keep the word after a taken redirect (no squash).
module id_redirect_stage
    import mips_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic [31:0]      pc_plus4,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             idex_mem_read,
    input  logic             idex_reg_write,
    input  logic [4:0]       idex_dst,
    output logic [4:0]       id_rs,
    output logic [4:0]       id_rt,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc_plus4,
    output logic             id_valid,
    output logic [31:0]      shifted_inst_extended,
    output logic [25:0]      jmp_addr,
    output logic [1:0]       Jmp,
    output logic             and_z_b,
    output logic [31:0]      read_data1_reg,
    output logic             pc_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       fsm_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    id_state_e  state;
    logic       stall;
    logic       redirect;
    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = id_instr[31:26];
    assign funct  = id_instr[5:0];
    assign id_rs  = id_instr[25:21];
    assign id_rt  = id_instr[20:16];

    id_hazard_unit u_hazard (
        .id_valid       (id_valid),
        .opcode         (opcode),
        .funct          (funct),
        .rs             (id_rs),
        .rt             (id_rt),
        .idex_mem_read  (idex_mem_read),
        .idex_reg_write (idex_reg_write),
        .idex_dst       (idex_dst),
        .stall          (stall)
    );

    assign shifted_inst_extended = branch_offset(id_instr[15:0]);
    assign jmp_addr              = id_instr[25:0];
    assign read_data1_reg        = rs_data;
    assign pc_hold               = stall;
    assign fsm_state             = state;

    // A bubble or a stalled slot must never steer fetch.
    always_comb begin
        Jmp     = JMP_SEQ;
        and_z_b = 1'b0;
        if (id_valid && !stall) begin
            if (opcode == OP_J || opcode == OP_JAL) begin
                Jmp = JMP_ABS;
            end else if (opcode == OP_RTYPE && funct == FUNCT_JR) begin
                Jmp = JMP_REG;
            end
            if (opcode == OP_BEQ) begin
                and_z_b = (rs_data == rt_data);
            end else if (opcode == OP_BNE) begin
                and_z_b = (rs_data != rt_data);
            end
        end
    end

    assign redirect = (Jmp != JMP_SEQ) || and_z_b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            id_instr    <= NOP_INSTR;
            id_pc_plus4 <= 32'd0;
            id_valid    <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state <= stall ? STALL : RUN;
            if (stall) begin
                if (stall_cnt != '1) begin
                    stall_cnt <= stall_cnt + CNT_ONE;
                end
            end else if (redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
                id_instr    <= instruction;
                id_pc_plus4 <= pc_plus4;
                id_valid    <= 1'b1;
`else
                id_instr    <= NOP_INSTR;
                id_pc_plus4 <= pc_plus4;
                id_valid    <= 1'b0;
                if (flush_cnt != '1) begin
                    flush_cnt <= flush_cnt + CNT_ONE;
                end
`endif
            end else begin
                id_instr    <= instruction;
                id_pc_plus4 <= pc_plus4;
                id_valid    <= 1'b1;
            end
        end
    end

endmodule
